// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: off patterns, hex glyphs, digit indices.
// Latency: none (constants only).
// Backpressure: none (constants only).
package seg_pkg;

   // All cathodes / all anodes released (both active-low).
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   // Digit index: 0 is the rightmost digit (disp_data[3:0]).
   typedef logic [1:0] dig_idx_t;
   localparam dig_idx_t DIG0 = 2'd0;
   localparam dig_idx_t DIG1 = 2'd1;
   localparam dig_idx_t DIG2 = 2'd2;
   localparam dig_idx_t DIG3 = 2'd3;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4b in) -> seg (7b out, {g,f,e,d,c,b,a}, active-low).
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = SEG_HEX_0;
         4'h1: seg = SEG_HEX_1;
         4'h2: seg = SEG_HEX_2;
         4'h3: seg = SEG_HEX_3;
         4'h4: seg = SEG_HEX_4;
         4'h5: seg = SEG_HEX_5;
         4'h6: seg = SEG_HEX_6;
         4'h7: seg = SEG_HEX_7;
         4'h8: seg = SEG_HEX_8;
         4'h9: seg = SEG_HEX_9;
         4'hA: seg = SEG_HEX_A;
         4'hB: seg = SEG_HEX_B;
         4'hC: seg = SEG_HEX_C;
         4'hD: seg = SEG_HEX_D;
         4'hE: seg = SEG_HEX_E;
         4'hF: seg = SEG_HEX_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode display scanner: one hex nibble per digit, frame-latched input word.
// Latency: 1 cycle from idx/shadow/blank to an/seg.
// Backpressure: none; disp_data is a level sampled once per frame at the last cycle of digit 3.
// Ports: clk, rst_n (sync, active-low), disp_data[15:0], blank -> an[3:0], seg[6:0], dp
//        (all outputs active-low; dp is always off).
// Option: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] disp_data,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt;
   dig_idx_t         idx;
   logic [15:0]      shadow;

   logic             cnt_wrap;
   logic             frame_end;
   logic [3:0]       cur_nibble;
   logic [6:0]       dec_seg;
   logic             digit_lit;
   logic [3:0]       an_nxt;
   logic [6:0]       seg_nxt;

   assign cnt_wrap   = (cnt == CNT_LAST);
   assign frame_end  = cnt_wrap && (idx == DIG3);
   assign cur_nibble = shadow[{idx, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .nibble (cur_nibble),
      .seg    (dec_seg)
   );

   // A digit is lit unless it is a leading zero (option) or the display is blanked.
   always_comb begin
      digit_lit = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      case (idx)
         DIG3:    digit_lit = (shadow[15:12] != 4'h0);
         DIG2:    digit_lit = (shadow[15:8]  != 8'h00);
         DIG1:    digit_lit = (shadow[15:4]  != 12'h000);
         default: digit_lit = 1'b1;
      endcase
`endif
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      if (!blank && digit_lit) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         idx    <= DIG0;
         shadow <= 16'h0000;
         an     <= AN_OFF;
         seg    <= SEG_OFF;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
         if (cnt_wrap) begin
            idx <= idx + 2'd1;
         end
         // Latch only at the frame boundary so a frame never mixes two words.
         if (frame_end) begin
            shadow <= disp_data;
         end
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

   logic        clk;
   logic        rst_n;
   logic [15:0] disp_data;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks;
   int errors;

   logic [6:0] exp_seg [4];
   logic [3:0] exp_an  [4];

   seven_seg_scanner #(
      .REFRESH_DIV (4),
      .CNT_W       (17)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .disp_data (disp_data),
      .blank     (blank),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input logic [27:0] segs, input logic [15:0] ans);
      // segs packs digit3..digit0 glyphs, ans packs digit3..digit0 anodes.
      for (int d = 0; d < 4; d++) begin
         exp_seg[d] = segs[7*d +: 7];
         exp_an[d]  = ans[4*d +: 4];
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      blank     = 1'b0;
      disp_data = 16'h12AB;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL reset: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", an, seg, dp);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (an !== 4'b1110 || seg !== 7'h40) begin
         errors++;
         $display("FAIL reset_first: an=%b seg=%h, want an=1110 seg=40", an, seg);
      end
   endtask

   // Rest of the zero frame, then two frames of 12AB.
   task automatic test_scan();
`ifdef SEG_LEADING_ZERO_BLANK_EN
      set_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'b1111, 4'b1111, 4'b1111, 4'b1110});
`else
      set_frame({7'h40, 7'h40, 7'h40, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
`endif
      for (int i = 1; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
            errors++;
            $display("FAIL scan_zero[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[i/4], exp_seg[i/4]);
         end
      end
      set_frame({7'h79, 7'h24, 7'h08, 7'h03}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (an !== exp_an[(i%16)/4] || seg !== exp_seg[(i%16)/4]) begin
            errors++;
            $display("FAIL scan_12ab[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[(i%16)/4], exp_seg[(i%16)/4]);
         end
      end
   endtask

   task automatic test_tear_free();
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
            errors++;
            $display("FAIL tear_old[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[i/4], exp_seg[i/4]);
         end
         if (i == 4) disp_data = 16'hFFFF;
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== 7'h0E) begin
            errors++;
            $display("FAIL tear_new[%0d]: an=%b seg=%h, want an=%b seg=0e", i, an, seg, exp_an[i/4]);
         end
      end
   endtask

   task automatic test_blank();
      logic [3:0] want_an;
      logic [6:0] want_seg;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i >= 5 && i <= 10) begin
            want_an  = 4'b1111;
            want_seg = 7'h7F;
         end else begin
            want_an  = exp_an[i/4];
            want_seg = 7'h0E;
         end
         checks++;
         if (an !== want_an || seg !== want_seg) begin
            errors++;
            $display("FAIL blank[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, want_an, want_seg);
         end
         if (i == 4)  blank = 1'b1;
         if (i == 10) blank = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (an !== 4'b1011 || seg !== 7'h0E) begin
         errors++;
         $display("FAIL rst_mid_pre: an=%b seg=%h, want an=1011 seg=0e", an, seg);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", an, seg, dp);
      end
      rst_n = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      set_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'b1111, 4'b1111, 4'b1111, 4'b1110});
`else
      set_frame({7'h40, 7'h40, 7'h40, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
`endif
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
            errors++;
            $display("FAIL rst_restart[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[i/4], exp_seg[i/4]);
         end
      end
   endtask

   task automatic test_leading_zero();
      // Shadow holds FFFF here; this frame latches 0005 at its end.
      disp_data = 16'h0005;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (seg !== 7'h0E) begin
            errors++;
            $display("FAIL lz_prev[%0d]: seg=%h, want 0e", i, seg);
         end
      end
`ifdef SEG_LEADING_ZERO_BLANK_EN
      set_frame({7'h7F, 7'h7F, 7'h7F, 7'h12}, {4'b1111, 4'b1111, 4'b1111, 4'b1110});
`else
      set_frame({7'h40, 7'h40, 7'h40, 7'h12}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
`endif
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
            errors++;
            $display("FAIL lz_0005[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[i/4], exp_seg[i/4]);
         end
         if (i == 2) disp_data = 16'h0100;
      end
`ifdef SEG_LEADING_ZERO_BLANK_EN
      set_frame({7'h7F, 7'h79, 7'h40, 7'h40}, {4'b1111, 4'b1011, 4'b1101, 4'b1110});
`else
      set_frame({7'h40, 7'h79, 7'h40, 7'h40}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
`endif
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (an !== exp_an[i/4] || seg !== exp_seg[i/4]) begin
            errors++;
            $display("FAIL lz_0100[%0d]: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an[i/4], exp_seg[i/4]);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      blank     = 1'b0;
      disp_data = 16'h0000;
      test_reset();
      test_scan();
      test_tear_free();
      test_blank();
      test_reset_mid();
      test_leading_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
